// File: rtl/conf_int_sub__ff__arch_agnos.sv
// Two-stage registered subtractor with configurable operand precision and valid/ready flow control.
// Stage 1 holds the truncated operands. Stage 2 holds the difference, with the borrow/sign bit as its MSB.
module conf_int_sub__ff__arch_agnos #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_PATH_BITWIDTH:0]   d,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int DP    = DATA_PATH_BITWIDTH;
    localparam int TRUNC = (OP_BITWIDTH >= DP) ? 0 : DP - OP_BITWIDTH;
    localparam logic [DP-1:0] KEEP_MASK = {DP{1'b1}} << TRUNC;

    generate
        if (OP_BITWIDTH < 1) begin : g_bad_op_bitwidth
            $error("OP_BITWIDTH must be at least 1");
        end
    endgenerate

    logic [DP-1:0] a_q, a_d;
    logic [DP-1:0] b_q, b_d;
    logic          s1_valid_q, s1_valid_d;
    logic [DP:0]   diff_q, diff_d;
    logic          out_valid_q, out_valid_d;

    logic s1_free, s2_free, load_s1, load_s2;

    // NOTE: every signal written here gets a value on every path; otherwise a latch is inferred.
    always_comb begin
        s2_free     = !out_valid_q || out_ready;
        s1_free     = !s1_valid_q || s2_free;
        load_s1     = in_valid && s1_free;
        load_s2     = s1_valid_q && s2_free;

        a_d         = a_q;
        b_d         = b_q;
        s1_valid_d  = s1_valid_q;
        diff_d      = diff_q;
        out_valid_d = out_valid_q;

        // A stage that drains and refills in the same cycle keeps its valid bit set, so no bubble appears.
        if (load_s2) begin
            diff_d      = {1'b0, a_q} - {1'b0, b_q};
            out_valid_d = 1'b1;
            s1_valid_d  = 1'b0;
        end else if (s2_free) begin
            out_valid_d = 1'b0;
        end

        if (load_s1) begin
            a_d        = a & KEEP_MASK;
            b_d        = b & KEEP_MASK;
            s1_valid_d = 1'b1;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            s1_valid_q  <= 1'b0;
            diff_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            s1_valid_q  <= s1_valid_d;
            diff_q      <= diff_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = s1_free;
    assign d         = diff_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conf_int_sub__ff__arch_agnos.sv
// Bench for the pipelined subtractor. It runs a full-precision instance and an 8-bit-precision instance side by side.
// Expected values come from a plain-arithmetic model and a queue of accepted transactions.
module tb_conf_int_sub__ff__arch_agnos;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        in_valid, out_ready;
    logic        in_ready_f, out_valid_f, in_ready_t, out_valid_t;
    logic [16:0] d_f, d_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int          acc;
        logic [16:0] exp_f;
        logic [16:0] exp_t;
    } txn_t;
    txn_t q[$];

    always #5 clk = ~clk;

    conf_int_sub__ff__arch_agnos #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(16)) dut_full (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready_f),
        .d(d_f), .out_valid(out_valid_f), .out_ready(out_ready)
    );

    conf_int_sub__ff__arch_agnos #(.OP_BITWIDTH(8), .DATA_PATH_BITWIDTH(16)) dut_trunc (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready_t),
        .d(d_t), .out_valid(out_valid_t), .out_ready(out_ready)
    );

    // Reference: drop the low bits, subtract as integers, then wrap negatives into 17 bits.
    function automatic logic [16:0] model(int unsigned av, int unsigned bv, int op);
        int t, at, bt, diff;
        t    = (op >= 16) ? 0 : 16 - op;
        at   = int'((av >> t) << t);
        bt   = int'((bv >> t) << t);
        diff = at - bt;
        if (diff < 0) diff += 1 << 17;
        return 17'(diff);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
    endtask

    task automatic test_reset();
        drive(1'b0, 16'h0, 16'h0);
        out_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid_f !== 1'b0 || out_valid_t !== 1'b0)
            $display("FAIL reset_out_valid got %b/%b want 0/0", out_valid_f, out_valid_t);
        else n_pass++;
        n_checks++;
        if (d_f !== 17'h0 || d_t !== 17'h0) $display("FAIL reset_d got %h/%h want 0/0", d_f, d_t);
        else n_pass++;
        n_checks++;
        if (in_ready_f !== 1'b1 || in_ready_t !== 1'b1)
            $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready_f, in_ready_t);
        else n_pass++;
    endtask

    // One accepted vector: check the 2-cycle latency and both precisions, then drain.
    task automatic send_one(input string name, input logic [15:0] av, input logic [15:0] bv);
        logic [16:0] ef, et;
        ef = model(av, bv, 16);
        et = model(av, bv, 8);
        out_ready = 1'b1;
        drive(1'b1, av, bv);
        #1;
        n_checks++;
        if (in_ready_f !== 1'b1) $display("FAIL %s_in_ready got %b want 1", name, in_ready_f);
        else n_pass++;
        cycle();
        drive(1'b0, 16'h0, 16'h0);
        #1;
        n_checks++;
        if (out_valid_f !== 1'b0) $display("FAIL %s_early_valid got %b want 0", name, out_valid_f);
        else n_pass++;
        cycle();
        n_checks++;
        if (out_valid_f !== 1'b1 || d_f !== ef)
            $display("FAIL %s_full got v=%b d=%h want v=1 d=%h", name, out_valid_f, d_f, ef);
        else n_pass++;
        n_checks++;
        if (out_valid_t !== 1'b1 || d_t !== et)
            $display("FAIL %s_trunc got v=%b d=%h want v=1 d=%h", name, out_valid_t, d_t, et);
        else n_pass++;
        cycle();
        n_checks++;
        if (out_valid_f !== 1'b0 || d_f !== ef)
            $display("FAIL %s_drain got v=%b d=%h want v=0 d=%h", name, out_valid_f, d_f, ef);
        else n_pass++;
    endtask

    task automatic test_basic();
        send_one("basic_sub", 16'h1234, 16'h0034);
        send_one("basic_neg", 16'h0000, 16'h0001);
        send_one("basic_eq",  16'hFFFF, 16'hFFFF);
        send_one("trunc",     16'h12FF, 16'h0101);
        n_checks++;
        if (d_t !== 17'h01100) $display("FAIL trunc_const got %h want 01100", d_t);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int av[4] = '{10, 20, 30, 40};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 16'(av[i]), 16'd1);
            else       drive(1'b0, 16'h0, 16'h0);
            #1;
            n_checks++;
            if (in_ready_f !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready_f);
            else n_pass++;
            cycle();
            if (i >= 1) begin
                n_checks++;
                if (out_valid_f !== 1'b1 || d_f !== 17'(av[i-1] - 1))
                    $display("FAIL b2b_out[%0d] got v=%b d=%0d want v=1 d=%0d", i - 1, out_valid_f, d_f, av[i-1] - 1);
                else n_pass++;
            end
        end
        drive(1'b0, 16'h0, 16'h0);
        cycle();
    endtask

    // Fill both stages while downstream stalls; the third offer must wait.
    task automatic fill_stalled();
        out_ready = 1'b0;
        drive(1'b1, 16'd5, 16'd2);
        cycle();
        drive(1'b1, 16'd6, 16'd2);
        cycle();
        drive(1'b1, 16'd7, 16'd2);
        #1;
    endtask

    task automatic test_backpressure();
        fill_stalled();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready_f !== 1'b0 || out_valid_f !== 1'b1 || d_f !== 17'd3)
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%0d want rdy=0 v=1 d=3", i, in_ready_f, out_valid_f, d_f);
            else n_pass++;
            cycle();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready_f !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready_f);
        else n_pass++;
        cycle();
        drive(1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (out_valid_f !== 1'b1 || d_f !== 17'(4 + i))
                $display("FAIL bp_order[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid_f, d_f, 4 + i);
            else n_pass++;
            cycle();
        end
        n_checks++;
        if (out_valid_f !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid_f);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        fill_stalled();
        drive(1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid_f !== 1'b0 || d_f !== 17'h0 || in_ready_f !== 1'b1)
            $display("FAIL midrst got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", out_valid_f, d_f, in_ready_f);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (out_valid_f !== 1'b0 || out_valid_t !== 1'b0)
                $display("FAIL midrst_stale[%0d] got %b/%b want 0/0", i, out_valid_f, out_valid_t);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit          rdy_exp, ov_exp;
        logic [15:0] av, bv;
        q.delete();
        for (int i = 0; i < 400; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            drive(1'($urandom_range(0, 1)), av, bv);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy_exp = (q.size() < 2) || out_ready;
            ov_exp  = (q.size() > 0) && (cyc >= q[0].acc + 2);
            n_checks++;
            if (in_ready_f !== rdy_exp || in_ready_t !== rdy_exp)
                $display("FAIL rnd_in_ready[%0d] got %b/%b want %b", i, in_ready_f, in_ready_t, rdy_exp);
            else n_pass++;
            n_checks++;
            if (out_valid_f !== ov_exp || out_valid_t !== ov_exp)
                $display("FAIL rnd_out_valid[%0d] got %b/%b want %b", i, out_valid_f, out_valid_t, ov_exp);
            else n_pass++;
            if (ov_exp) begin
                n_checks++;
                if (d_f !== q[0].exp_f || d_t !== q[0].exp_t)
                    $display("FAIL rnd_d[%0d] got %h/%h want %h/%h", i, d_f, d_t, q[0].exp_f, q[0].exp_t);
                else n_pass++;
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && rdy_exp) q.push_back('{cyc, model(av, bv, 16), model(av, bv, 8)});
            cycle();
        end
        drive(1'b0, 16'h0, 16'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 6 && q.size() > 0; i++) begin
            #1;
            if (cyc >= q[0].acc + 2) begin
                n_checks++;
                if (out_valid_f !== 1'b1 || d_f !== q[0].exp_f || d_t !== q[0].exp_t)
                    $display("FAIL rnd_flush got v=%b d=%h/%h want v=1 d=%h/%h", out_valid_f, d_f, d_t, q[0].exp_f, q[0].exp_t);
                else n_pass++;
                void'(q.pop_front());
            end
            cycle();
        end
        n_checks++;
        if (q.size() != 0 || out_valid_f !== 1'b0)
            $display("FAIL rnd_drain got left=%0d v=%b want left=0 v=0", q.size(), out_valid_f);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0);
        out_ready = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
